// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver with receive FIFO.
// Holds the receiver state enum, the baud divider calculation and counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Rounded divide so that e.g. 50 MHz / (9600 * 16) gives 326, not 325.
  function automatic int tick_div(input int f_clock, input int baudrate, input int sampling);
    int den;
    den = baudrate * sampling;
    return (f_clock + den / 2) / den;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversampling tick: one-cycle pulse every round(F_CLOCK/(BAUDRATE*SAMPLING)) clocks.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int F_CLOCK  = 50_000_000,
  parameter int BAUDRATE = 9600,
  parameter int SAMPLING = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV = tick_div(F_CLOCK, BAUDRATE, SAMPLING);
  localparam int CW  = cnt_width(DIV);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start/data/[parity]/stop FSM) feeding a first-word-fall-through FIFO.
// Parity bit checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int F_CLOCK    = 50_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int SAMPLING   = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_rx,
  input  logic                          i_rd,
  input  logic                          i_err_clr,
  output logic [N_BITS-1:0]             o_data,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_parity_err
);

  localparam int   SW      = $clog2(SAMPLING);
  localparam int   NW      = $clog2(N_BITS);
  localparam int   AW      = $clog2(FIFO_DEPTH);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic tick;

  baud_tick_gen #(
    .F_CLOCK (F_CLOCK),
    .BAUDRATE(BAUDRATE),
    .SAMPLING(SAMPLING)
  ) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e         state_q;
  logic [SW-1:0]     s_q;
  logic [NW-1:0]     n_q;
  logic [N_BITS-1:0] shreg_q;
  logic              frame_bad_q, par_bad_q;
  logic              push_q, frame_ev_q, par_ev_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shreg_q     <= '0;
      frame_bad_q <= 1'b0;
      par_bad_q   <= 1'b0;
      push_q      <= 1'b0;
      frame_ev_q  <= 1'b0;
      par_ev_q    <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      frame_ev_q <= 1'b0;
      par_ev_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Requiring a high-to-low transition keeps a held break from re-triggering.
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_q == SW'(SAMPLING / 2 - 1)) begin
              s_q <= '0;
              n_q <= '0;
              state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_q == SW'(SAMPLING - 1)) begin
              s_q     <= '0;
              shreg_q <= {rx_sync_q, shreg_q[N_BITS-1:1]};
              if (n_q == NW'(N_BITS - 1)) begin
                n_q         <= '0;
                frame_bad_q <= 1'b0;
                par_bad_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                state_q     <= ST_PARITY;
`else
                state_q     <= ST_STOP;
`endif
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (s_q == SW'(SAMPLING - 1)) begin
              s_q       <= '0;
              par_bad_q <= ((^{shreg_q, rx_sync_q}) != PAR_ODD);
              state_q   <= ST_STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (s_q == SW'(SAMPLING - 1)) begin
              s_q <= '0;
              if (n_q == NW'(STOP_BITS - 1)) begin
                n_q        <= '0;
                state_q    <= ST_IDLE;
                push_q     <= !(frame_bad_q || !rx_sync_q) && !par_bad_q;
                frame_ev_q <= frame_bad_q || !rx_sync_q;
                par_ev_q   <= par_bad_q;
              end else begin
                frame_bad_q <= frame_bad_q || !rx_sync_q;
                n_q         <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level;
  logic              empty, full, pop, wr_en;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d, par_err_q, par_err_d;
  logic [N_BITS-1:0] mem_q [FIFO_DEPTH];

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = level[AW];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = i_rd && !empty;
    wr_en    = push_q && (!full || pop);
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    // A new error event outranks a simultaneous clear.
    frame_err_d = frame_ev_q || (frame_err_q && !i_err_clr);
    par_err_d   = par_ev_q || (par_err_q && !i_err_clr);
    overrun_d   = (push_q && full && !pop) || (overrun_q && !i_err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
  end

  assign o_data       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_level      = level;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;
  assign o_parity_err = par_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus random bursts against a queue model.
// Runs a fast line rate (3 clocks per tick, 48 clocks per bit) to keep simulation short.
module tb_uart_rx_fifo;

  localparam int N_BITS     = 8;
  localparam int F_CLOCK    = 1_000_000;
  localparam int BAUDRATE   = 20_000;
  localparam int SAMPLING   = 16;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 8;
  localparam int PARITY_ODD = 0;
  // round(1e6 / (20000*16)) = round(3.125) = 3 clocks per tick.
  localparam int BIT_CLKS   = 3 * SAMPLING;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        rx;
  logic                        rd;
  logic                        err_clr;
  logic [N_BITS-1:0]           data;
  logic                        empty, full;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        frame_err, overrun, parity_err;

  uart_rx_fifo #(
    .N_BITS    (N_BITS),
    .F_CLOCK   (F_CLOCK),
    .BAUDRATE  (BAUDRATE),
    .SAMPLING  (SAMPLING),
    .STOP_BITS (STOP_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx        (rx),
    .i_rd        (rd),
    .i_err_clr   (err_clr),
    .o_data      (data),
    .o_empty     (empty),
    .o_full      (full),
    .o_level     (level),
    .o_frame_err (frame_err),
    .o_overrun   (overrun),
    .o_parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N_BITS-1:0] model_q[$];
  bit m_frame, m_ovr, m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, ".level"}, 32'(level), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == FIFO_DEPTH));
    check({tag, ".ferr"},  32'(frame_err), 32'(m_frame));
    check({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
    check({tag, ".perr"},  32'(parity_err), 32'(m_par));
    if (model_q.size() != 0) check({tag, ".head"}, 32'(data), 32'(model_q[0]));
  endtask

  task automatic hold_bits(input int nbits);
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  // Serialise one frame: start, data LSB first, optional parity, stop bit(s), one idle bit.
  task automatic send_frame(input logic [N_BITS-1:0] d, input bit stop_ok, input bit par_flip);
    @(negedge clk);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < N_BITS; i++) begin
      rx = d[i];
      hold_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ (PARITY_ODD != 0) ^ par_flip;
    hold_bits(1);
`endif
    for (int k = 0; k < STOP_BITS; k++) begin
      rx = (k == 0) ? stop_ok : 1'b1;
      hold_bits(1);
    end
    rx = 1'b1;
    hold_bits(1);
  endtask

  task automatic model_frame(input logic [N_BITS-1:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok) m_frame = 1'b1;
    if (!par_ok)  m_par   = 1'b1;
    if (stop_ok && par_ok) begin
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic frame(input string tag, input logic [N_BITS-1:0] d, input bit stop_ok);
    send_frame(d, stop_ok, 1'b0);
    model_frame(d, stop_ok, 1'b1);
    check_state(tag);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, ".pop_data"}, 32'(data), 32'(model_q[0]));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    void'(model_q.pop_front());
    check_state(tag);
  endtask

  task automatic clear_errors(input string tag);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_frame = 1'b0;
    m_ovr   = 1'b0;
    m_par   = 1'b0;
    check_state(tag);
  endtask

  initial begin
    int n;
    int t;
    bit seen;
    logic [N_BITS-1:0] d;
    bit ok;

    reset   = 1'b1;
    rx      = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("reset.data", 32'(data), 32'h0);
    check_state("reset");

    // Pop on an empty FIFO must do nothing.
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_state("pop_empty");

    frame("a5", 8'hA5, 1'b1);
    pop_check("a5");

    frame("3c_badstop", 8'h3C, 1'b0);
    clear_errors("3c_clr");

    // Start glitch of three ticks: must fall back to idle silently.
    @(negedge clk);
    rx = 1'b0;
    repeat (9) @(negedge clk);
    rx = 1'b1;
    hold_bits(2);
    check_state("glitch");
    frame("after_glitch", 8'hC3, 1'b1);
    pop_check("after_glitch");

    // Break: line held low far past a frame, then released.
    @(negedge clk);
    rx = 1'b0;
    hold_bits(15);
    m_frame = 1'b1;
    check_state("break_low");
    rx = 1'b1;
    hold_bits(2);
    frame("after_break", 8'h5A, 1'b1);
    pop_check("after_break");
    clear_errors("break_clr");

    // Reset in the middle of a frame discards it.
    @(negedge clk);
    rx = 1'b0;
    hold_bits(1);
    rx = 1'b1;
    hold_bits(2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold_bits(12);
    check_state("reset_midframe");

    for (int i = 1; i <= 9; i++) frame("fill9", N_BITS'(i), 1'b1);
    for (int i = 0; i < 8; i++) pop_check("drain9");
    clear_errors("fill9_clr");

    // Full FIFO with a pop on the exact push cycle: word accepted, no overrun.
    for (int i = 0; i < FIFO_DEPTH; i++) frame("fill8", N_BITS'(8'h10 + i), 1'b1);
    seen = 1'b0;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        t = 0;
        while (dut.push_q !== 1'b1 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        if (t < 3000) begin
          seen = 1'b1;
          check("push_pop.head", 32'(data), 32'(model_q[0]));
          rd = 1'b1;
          @(negedge clk);
          rd = 1'b0;
          void'(model_q.pop_front());
          model_q.push_back(8'h77);
        end
      end
    join
    check("push_pop.seen", 32'(seen), 32'h1);
    check_state("push_pop");
    while (model_q.size() > 0) pop_check("push_pop_drain");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b0);
    check_state("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b1);
    check_state("par_good");
    pop_check("par_good");
    clear_errors("par_clr");
`endif

    // Random bursts with occasional bad stop bits, drained in random-length chunks.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(2, 5);
      for (int j = 0; j < n; j++) begin
        d  = N_BITS'($urandom);
        ok = ($urandom_range(0, 4) != 0);
        frame("rand", d, ok);
      end
      while (model_q.size() > 0) pop_check("rand_drain");
      clear_errors("rand_clr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
